// File: rtl/pc_gen_pkg.sv
// Shared constants for the program-counter generator: FSM state encoding,
// sequential fetch step and instruction alignment helpers.
package pc_gen_pkg;

   // FSM state encoding, kept as plain constants for compatibility with
   // older blocks that compare against raw state values.
   localparam logic [1:0] ST_BOOT       = 2'd0;
   localparam logic [1:0] ST_RUN        = 2'd1;
   localparam logic [1:0] ST_TRAP_ENTRY = 2'd2;

   // Byte distance between consecutive sequential fetches.
   localparam int PC_STEP = 4;

   // Low address bits that must be zero for a legal instruction address.
   localparam logic [1:0] ALIGN_MASK = 2'b11;

   // True when the two low address bits describe a 4-byte aligned address.
   function automatic logic is_aligned(input logic [1:0] low_bits);
      return (low_bits & ALIGN_MASK) == 2'b00;
   endfunction

endpackage : pc_gen_pkg

// File: rtl/pc_next_sel.sv
// Next-PC selection: combinational priority mux over trap, jump, branch,
// stall and fetch acceptance, plus the alignment check on redirect targets.
// Only meaningful while the FSM is in RUN; the parent ignores it otherwise.
module pc_next_sel
   import pc_gen_pkg::*;
#(
   parameter int                  PC_WIDTH    = 32,
   parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = PC_WIDTH'(32'h0000_0100)
) (
   input  logic [PC_WIDTH-1:0] pc,
   input  logic                stall,
   input  logic                fetch_ready,
   input  logic                br_taken,
   input  logic [PC_WIDTH-1:0] br_offset,
   input  logic                jump,
   input  logic [PC_WIDTH-1:0] jump_target,
   input  logic                trap,
   output logic [PC_WIDTH-1:0] next_pc,
   output logic                enter_trap,
   output logic                misalign,
   output logic [PC_WIDTH-1:0] bad_target,
   output logic                accept
);

   logic [PC_WIDTH-1:0] br_target;

   // Branch target wraps naturally modulo 2^PC_WIDTH; a negative offset is
   // just its two's-complement pattern.
   assign br_target = pc + br_offset;

   // Priority: trap > jump > branch > stall > accept > hold.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      next_pc    = pc;
      enter_trap = 1'b0;
      misalign   = 1'b0;
      bad_target = '0;
      accept     = 1'b0;

      if (trap) begin
         next_pc    = TRAP_VECTOR;
         enter_trap = 1'b1;
      end else if (jump) begin
         if (is_aligned(jump_target[1:0])) begin
            next_pc = jump_target;
         end else begin
            next_pc    = TRAP_VECTOR;
            enter_trap = 1'b1;
            misalign   = 1'b1;
            bad_target = jump_target;
         end
      end else if (br_taken) begin
         if (is_aligned(br_target[1:0])) begin
            next_pc = br_target;
         end else begin
            next_pc    = TRAP_VECTOR;
            enter_trap = 1'b1;
            misalign   = 1'b1;
            bad_target = br_target;
         end
      end else if (!stall && fetch_ready) begin
         next_pc = pc + PC_WIDTH'(PC_STEP);
         accept  = 1'b1;
      end
   end

endmodule : pc_next_sel

// File: rtl/pc_gen.sv
// Program-counter generator: holds the PC, the boot/run/trap-entry FSM, the
// misalignment report registers and the accepted-fetch counter.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int                  PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(32'h0000_0100),
   parameter int                  CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 fetch_ready,
   input  logic                 br_taken,
   input  logic [PC_WIDTH-1:0]  br_offset,
   input  logic                 jump,
   input  logic [PC_WIDTH-1:0]  jump_target,
   input  logic                 trap,
   output logic [PC_WIDTH-1:0]  pc,
   output logic                 pc_valid,
   output logic                 misalign_err,
   output logic [PC_WIDTH-1:0]  bad_addr,
   output logic [CNT_WIDTH-1:0] fetch_cnt
);

   logic [1:0]          state;
   logic [PC_WIDTH-1:0] next_pc;
   logic                enter_trap;
   logic                misalign;
   logic [PC_WIDTH-1:0] bad_target;
   logic                accept;

   pc_next_sel #(
      .PC_WIDTH    (PC_WIDTH),
      .TRAP_VECTOR (TRAP_VECTOR)
   ) u_next_sel (
      .pc          (pc),
      .stall       (stall),
      .fetch_ready (fetch_ready),
      .br_taken    (br_taken),
      .br_offset   (br_offset),
      .jump        (jump),
      .jump_target (jump_target),
      .trap        (trap),
      .next_pc     (next_pc),
      .enter_trap  (enter_trap),
      .misalign    (misalign),
      .bad_target  (bad_target),
      .accept      (accept)
   );

   // Only RUN presents a fetch request; BOOT and the trap bubble do not.
   assign pc_valid = (state == ST_RUN);

   // FSM, PC, misalignment report and fetch counter; reset wins over all.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (reset) begin
         state        <= ST_BOOT;
         pc           <= RESET_VECTOR;
         misalign_err <= 1'b0;
         bad_addr     <= '0;
         fetch_cnt    <= '0;
      end else begin
         // The error flag is a single-cycle pulse unless re-raised below.
         misalign_err <= 1'b0;
         case (state)
            ST_BOOT: begin
               state <= ST_RUN;
               pc    <= RESET_VECTOR;
            end
            ST_RUN: begin
               pc <= next_pc;
               if (enter_trap) begin
                  state <= ST_TRAP_ENTRY;
               end
               if (misalign) begin
                  misalign_err <= 1'b1;
                  bad_addr     <= bad_target;
               end
               if (accept) begin
                  fetch_cnt <= fetch_cnt + CNT_WIDTH'(1);
               end
            end
            ST_TRAP_ENTRY: begin
               // One-cycle bubble at the trap vector; redirects ignored.
               state <= ST_RUN;
            end
            default: begin
               state <= ST_BOOT;
               pc    <= RESET_VECTOR;
            end
         endcase
      end
   end

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen. A second, narrow instance
// (10-bit PC, 3-bit counter) shares the stimulus to exercise wrap-around.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        fetch_ready;
   logic        br_taken;
   logic [31:0] br_offset;
   logic        jump;
   logic [31:0] jump_target;
   logic        trap;

   logic [31:0] pc;
   logic        pc_valid;
   logic        misalign_err;
   logic [31:0] bad_addr;
   logic [15:0] fetch_cnt;

   logic [9:0]  n_pc;
   logic        n_pc_valid;
   logic        n_misalign_err;
   logic [9:0]  n_bad_addr;
   logic [2:0]  n_fetch_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pc_gen dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .fetch_ready  (fetch_ready),
      .br_taken     (br_taken),
      .br_offset    (br_offset),
      .jump         (jump),
      .jump_target  (jump_target),
      .trap         (trap),
      .pc           (pc),
      .pc_valid     (pc_valid),
      .misalign_err (misalign_err),
      .bad_addr     (bad_addr),
      .fetch_cnt    (fetch_cnt)
   );

   pc_gen #(.PC_WIDTH(10), .CNT_WIDTH(3)) dut_narrow (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .fetch_ready  (fetch_ready),
      .br_taken     (br_taken),
      .br_offset    (br_offset[9:0]),
      .jump         (jump),
      .jump_target  (jump_target[9:0]),
      .trap         (trap),
      .pc           (n_pc),
      .pc_valid     (n_pc_valid),
      .misalign_err (n_misalign_err),
      .bad_addr     (n_bad_addr),
      .fetch_cnt    (n_fetch_cnt)
   );

   // Advance one rising edge and settle before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 1'b0; fetch_ready = 1'b0; br_taken = 1'b0; br_offset = '0;
      jump = 1'b0; jump_target = '0; trap = 1'b0;
   endtask

   task automatic test_reset();
      int exp_pc;
      idle();
      reset = 1'b1;
      tick(); tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected %h", pc, 32'h0); end
      checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", pc_valid); end
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", misalign_err); end
      checks++; if (bad_addr !== 32'h0) begin errors++; $display("FAIL rst_bad: got %h expected 0", bad_addr); end
      checks++; if (fetch_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h expected 0", fetch_cnt); end
      // Leave reset with sequential fetch requested: still BOOT until the edge.
      reset = 1'b0; fetch_ready = 1'b1;
      #1;
      checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b expected 0", pc_valid); end
      for (int i = 0; i < 5; i++) begin
         tick();
         exp_pc = 4 * i;
         checks++; if (pc !== 32'(exp_pc)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, exp_pc); end
         checks++; if (fetch_cnt !== 16'(i)) begin errors++; $display("FAIL seq_cnt[%0d]: got %0d expected %0d", i, fetch_cnt, i); end
         checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, pc_valid); end
      end
   endtask

   task automatic test_stall_branch();
      // Jump to 0x40 while accept is requested: a redirect does not count.
      idle(); fetch_ready = 1'b1; jump = 1'b1; jump_target = 32'h40;
      tick();
      checks++; if (pc !== 32'h40) begin errors++; $display("FAIL jmp_pc: got %h expected 40", pc); end
      checks++; if (fetch_cnt !== 16'd4) begin errors++; $display("FAIL jmp_cnt: got %0d expected 4", fetch_cnt); end
      idle(); stall = 1'b1; br_taken = 1'b1; br_offset = -32'sd8;
      tick();
      checks++; if (pc !== 32'h38) begin errors++; $display("FAIL br_pc: got %h expected 38", pc); end
      checks++; if (fetch_cnt !== 16'd4) begin errors++; $display("FAIL br_cnt: got %0d expected 4", fetch_cnt); end
      idle(); stall = 1'b1; fetch_ready = 1'b1;
      tick();
      checks++; if (pc !== 32'h38) begin errors++; $display("FAIL stall_pc: got %h expected 38", pc); end
      checks++; if (fetch_cnt !== 16'd4) begin errors++; $display("FAIL stall_cnt: got %0d expected 4", fetch_cnt); end
   endtask

   task automatic test_fetch_hold();
      idle(); jump = 1'b1; jump_target = 32'h20;
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (pc !== 32'h20) begin errors++; $display("FAIL hold_pc[%0d]: got %h expected 20", i, pc); end
         checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, pc_valid); end
         checks++; if (fetch_cnt !== 16'd4) begin errors++; $display("FAIL hold_cnt[%0d]: got %0d expected 4", i, fetch_cnt); end
      end
   endtask

   task automatic test_misalign();
      idle(); jump = 1'b1; jump_target = 32'h203;
      tick();
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL mis_pc: got %h expected 100", pc); end
      checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", misalign_err); end
      checks++; if (bad_addr !== 32'h203) begin errors++; $display("FAIL mis_bad: got %h expected 203", bad_addr); end
      checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL mis_valid: got %b expected 0", pc_valid); end
      // Redirect and accept during the trap bubble are both ignored.
      idle(); fetch_ready = 1'b1; jump = 1'b1; jump_target = 32'h400;
      tick();
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL bubble_pc: got %h expected 100", pc); end
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL bubble_err: got %b expected 0", misalign_err); end
      checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL bubble_valid: got %b expected 1", pc_valid); end
      checks++; if (fetch_cnt !== 16'd4) begin errors++; $display("FAIL bubble_cnt: got %0d expected 4", fetch_cnt); end
      idle(); fetch_ready = 1'b1;
      tick();
      checks++; if (pc !== 32'h104) begin errors++; $display("FAIL post_pc: got %h expected 104", pc); end
      checks++; if (fetch_cnt !== 16'd5) begin errors++; $display("FAIL post_cnt: got %0d expected 5", fetch_cnt); end
      // Branch to 0x104 + 2 = 0x106 is misaligned.
      idle(); br_taken = 1'b1; br_offset = 32'd2;
      tick();
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL brmis_pc: got %h expected 100", pc); end
      checks++; if (bad_addr !== 32'h106) begin errors++; $display("FAIL brmis_bad: got %h expected 106", bad_addr); end
      checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL brmis_err: got %b expected 1", misalign_err); end
      idle();
      tick();
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL brmis_pulse: got %b expected 0", misalign_err); end
      checks++; if (bad_addr !== 32'h106) begin errors++; $display("FAIL brmis_keep: got %h expected 106", bad_addr); end
   endtask

   task automatic test_trap_priority();
      idle(); trap = 1'b1; jump = 1'b1; jump_target = 32'h80; stall = 1'b1;
      tick();
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL trap_pc: got %h expected 100", pc); end
      checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL trap_valid: got %b expected 0", pc_valid); end
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL trap_err: got %b expected 0", misalign_err); end
      checks++; if (fetch_cnt !== 16'd5) begin errors++; $display("FAIL trap_cnt: got %0d expected 5", fetch_cnt); end
      // Reset during TRAP_ENTRY.
      idle(); reset = 1'b1; trap = 1'b1;
      tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL trst_pc: got %h expected 0", pc); end
      checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL trst_valid: got %b expected 0", pc_valid); end
      checks++; if (fetch_cnt !== 16'd0) begin errors++; $display("FAIL trst_cnt: got %0d expected 0", fetch_cnt); end
      checks++; if (bad_addr !== 32'h0) begin errors++; $display("FAIL trst_bad: got %h expected 0", bad_addr); end
      // BOOT ignores redirects and moves to RUN at the reset vector.
      reset = 1'b0; trap = 1'b1;
      tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL boot_pc: got %h expected 0", pc); end
      checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL boot_run: got %b expected 1", pc_valid); end
   endtask

   task automatic test_wrap();
      idle(); fetch_ready = 1'b1; jump = 1'b1; jump_target = 32'd1020;
      tick();
      checks++; if (n_pc !== 10'd1020) begin errors++; $display("FAIL wrap_start: got %0d expected 1020", n_pc); end
      idle(); fetch_ready = 1'b1;
      tick();
      checks++; if (n_pc !== 10'd0) begin errors++; $display("FAIL wrap_pc: got %0d expected 0", n_pc); end
      checks++; if (n_misalign_err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b expected 0", n_misalign_err); end
      checks++; if (n_pc_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b expected 1", n_pc_valid); end
      checks++; if (pc !== 32'h400) begin errors++; $display("FAIL wide_pc: got %h expected 400", pc); end
      for (int i = 0; i < 8; i++) tick();
      checks++; if (n_fetch_cnt !== 3'd1) begin errors++; $display("FAIL cnt_wrap: got %0d expected 1", n_fetch_cnt); end
      checks++; if (fetch_cnt !== 16'd9) begin errors++; $display("FAIL cnt_wide: got %0d expected 9", fetch_cnt); end
      checks++; if (n_pc !== 10'd32) begin errors++; $display("FAIL wrap_end: got %0d expected 32", n_pc); end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_stall_branch();
      test_fetch_hold();
      test_misalign();
      test_trap_priority();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Run-away guard; the directed sequence needs well under this.
   initial begin
      #50000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule : tb_pc_gen
